// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank: multi-channel conditioner for asynchronous board inputs.
// Each channel has an N-stage synchronizer, a stability-count debouncer and
// registered one-cycle rise/fall pulses on the debounced level.
// Optional latched press flags are enabled by defining SYNC_DEBOUNCE_STICKY_EN.
module sync_debounce_bank #(
    parameter int            CH        = 4,
    parameter int            STAGES    = 2,
    parameter int            DB_CYCLES = 16,
    parameter logic [CH-1:0] RST_VAL   = {CH{1'b0}}
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [CH-1:0] d,
    output logic [CH-1:0] q,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
`ifdef SYNC_DEBOUNCE_STICKY_EN
    ,
    output logic [CH-1:0] sticky,
    input  logic [CH-1:0] sticky_clr
`endif
);

    localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CH-1:0]    sync_p [STAGES];
    logic [CH-1:0]    sync_s;
    logic [CNT_W-1:0] cnt    [CH];
    logic [CH-1:0]    accept;

    assign sync_s = sync_p[STAGES-1];

    // Synchronizer shift chain: raw input enters stage 0, last stage feeds the debouncer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < STAGES; j++) begin
                sync_p[j] <= RST_VAL;
            end
        end else begin
            sync_p[0] <= d;
            for (int j = 1; j < STAGES; j++) begin
                sync_p[j] <= sync_p[j-1];
            end
        end
    end

    // A channel flips when the synced value has differed for the full count window.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CH; i++) begin
            accept[i] = (sync_s[i] != q[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-channel stability counter; any match with q restarts the window from zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= RST_VAL;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync_s[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    q[i]   <= sync_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge pulses are registered alongside the q update so they line up with the new level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= accept & sync_s;
            fall <= accept & ~sync_s;
        end
    end

`ifdef SYNC_DEBOUNCE_STICKY_EN
    // Press flags latch on a rise pulse; a clear on the same edge loses to the set.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | rise;
        end
    end
`endif

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Testbench for sync_debounce_bank (CH=4, STAGES=2, DB_CYCLES=16).
// Expected pulses are queued when stimulus is driven and matched by a monitor.
module tb_sync_debounce_bank;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
`ifdef SYNC_DEBOUNCE_STICKY_EN
    logic [3:0] sticky;
    logic [3:0] sticky_clr;
`endif

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef struct {
        int         edge_n;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;

    typedef struct {
        logic [3:0] dv;
        int         hold;
        int         rel;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] qx;
    } vec_t;

    ev_t  sbq[$];
    vec_t tbl[13];

    sync_debounce_bank #(
        .CH(4),
        .STAGES(2),
        .DB_CYCLES(16),
        .RST_VAL(4'h0)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .d(d),
        .q(q),
        .rise(rise),
        .fall(fall)
`ifdef SYNC_DEBOUNCE_STICKY_EN
        ,
        .sticky(sticky),
        .sticky_clr(sticky_clr)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) ecnt <= ecnt + 1;

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation, on the expected edge.
    always @(negedge Clk) begin
        ev_t e;
        if (sbq.size() > 0 && sbq[0].edge_n < ecnt) begin
            total++;
            bad++;
            $display("FAIL missing_pulse: no pulse observed, expected rise=%h fall=%h at edge %0d",
                     sbq[0].r, sbq[0].f, sbq[0].edge_n);
            void'(sbq.pop_front());
        end
        if ((rise | fall) !== 4'h0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got rise=%h fall=%h at edge %0d, expected none",
                         rise, fall, ecnt);
            end else begin
                e = sbq.pop_front();
                check_int("pulse_edge", ecnt, e.edge_n);
                check4("pulse_rise", rise, e.r);
                check4("pulse_fall", fall, e.f);
                check4("pulse_overlap", rise & fall, 4'h0);
            end
        end
    end

    // Drive one level for 'hold' cycles; a pulse, if any, is expected at row edge 'rel'.
    task automatic run_row(input string nm, input logic [3:0] dv, input int hold, input int rel,
                           input logic [3:0] r, input logic [3:0] f, input logic [3:0] qx);
        ev_t e;
        if ((r | f) != 4'h0) begin
            e.edge_n = ecnt + rel;
            e.r      = r;
            e.f      = f;
            sbq.push_back(e);
        end
        d = dv;
        repeat (hold) @(negedge Clk);
        check4({nm, "_q"}, q, qx);
    endtask

    initial begin
        ev_t ev;
        Reset = 1'b1;
        d     = 4'h0;
`ifdef SYNC_DEBOUNCE_STICKY_EN
        sticky_clr = 4'h0;
`endif
        //            d     hold rel  rise  fall  q
        tbl[0]  = '{4'h0, 20,  0, 4'h0, 4'h0, 4'h0};  // quiet after reset
        tbl[1]  = '{4'h1, 20, 18, 4'h1, 4'h0, 4'h1};  // ch0 press, edge 18
        tbl[2]  = '{4'h3, 10,  0, 4'h0, 4'h0, 4'h1};  // ch1 bounce high 10
        tbl[3]  = '{4'h1,  2,  0, 4'h0, 4'h0, 4'h1};  // ch1 bounce low 2
        tbl[4]  = '{4'h3, 20, 18, 4'h2, 4'h0, 4'h3};  // ch1 steady high
        tbl[5]  = '{4'h7,  1,  0, 4'h0, 4'h0, 4'h3};  // ch2 1-cycle glitch
        tbl[6]  = '{4'h3, 20,  0, 4'h0, 4'h0, 4'h3};
        tbl[7]  = '{4'h7, 15,  0, 4'h0, 4'h0, 4'h3};  // ch2 15-cycle pulse
        tbl[8]  = '{4'h3, 20,  0, 4'h0, 4'h0, 4'h3};
        tbl[9]  = '{4'h7, 16, 18, 4'h4, 4'h0, 4'h3};  // ch2 16-cycle pulse
        tbl[10] = '{4'h3, 20, 18, 4'h0, 4'h4, 4'h3};  // ch2 falls back
        tbl[11] = '{4'h0, 20, 18, 4'h0, 4'h3, 4'h0};  // ch0,ch1 fall together
        tbl[12] = '{4'hF, 20, 18, 4'hF, 4'h0, 4'hF};  // all rise together

        repeat (3) @(negedge Clk);
        check4("reset_q", q, 4'h0);
        check4("reset_rise", rise, 4'h0);
        check4("reset_fall", fall, 4'h0);
`ifdef SYNC_DEBOUNCE_STICKY_EN
        check4("reset_sticky", sticky, 4'h0);
`endif
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_row($sformatf("row%0d", i), tbl[i].dv, tbl[i].hold, tbl[i].rel,
                    tbl[i].r, tbl[i].f, tbl[i].qx);
        end

        // Reset asserted asynchronously at count 8 of a 1->0 transition.
        d = 4'h0;
        repeat (10) @(negedge Clk);
        check4("midcount_q_before", q, 4'hF);
        #2 Reset = 1'b1;
        #1;
        check4("async_reset_q", q, 4'h0);
        check4("async_reset_fall", fall, 4'h0);
`ifdef SYNC_DEBOUNCE_STICKY_EN
        check4("async_reset_sticky", sticky, 4'h0);
`endif
        @(negedge Clk);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        run_row("post_reset_quiet", 4'h0, 5, 0, 4'h0, 4'h0, 4'h0);
        run_row("post_reset_rise", 4'hF, 20, 18, 4'hF, 4'h0, 4'hF);

`ifdef SYNC_DEBOUNCE_STICKY_EN
        check4("sticky_set", sticky, 4'hF);
        sticky_clr = 4'hF;
        @(negedge Clk);
        sticky_clr = 4'h0;
        check4("sticky_clear_all", sticky, 4'h0);
        run_row("sticky_release", 4'h0, 20, 18, 4'h0, 4'hF, 4'h0);
        check4("sticky_after_release", sticky, 4'h0);
        ev.edge_n = ecnt + 18;
        ev.r      = 4'h1;
        ev.f      = 4'h0;
        sbq.push_back(ev);
        d = 4'h1;
        repeat (18) @(negedge Clk);
        check4("sticky_rise_visible", rise, 4'h1);
        sticky_clr = 4'h1;
        @(negedge Clk);
        sticky_clr = 4'h0;
        check4("sticky_set_wins", sticky, 4'h1);
        repeat (2) @(negedge Clk);
        check4("sticky_holds", sticky, 4'h1);
        sticky_clr = 4'h1;
        @(negedge Clk);
        sticky_clr = 4'h0;
        check4("sticky_clear_alone", sticky, 4'h0);
`endif

        repeat (25) @(negedge Clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL leftover_pulses: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
